// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial unsigned subtractor: d = (a - b - bin) mod 2^WIDTH plus borrow-out.
// A single full-subtractor cell and a borrow flip-flop process one bit per
// clock, LSB first. Operands enter and the result leaves via valid/ready.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] areg;
    logic [WIDTH-1:0] breg;
    logic [WIDTH-1:0] dreg;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             diffbit;
    logic             borrownext;

    // The full-subtractor cell working on the current LSB of each operand
    // register together with the stored borrow.
    assign diffbit    = areg[0] ^ breg[0] ^ borrow;
    assign borrownext = (~areg[0] & breg[0]) | (~(areg[0] ^ breg[0]) & borrow);

    assign d = dreg;

    // Handshake FSM and datapath. The result register only shifts in SHIFT,
    // so d and bout are frozen throughout DONE no matter what the inputs do.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            areg      <= '0;
            breg      <= '0;
            dreg      <= '0;
            borrow    <= 1'b0;
            bout      <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        areg     <= a;
                        breg     <= b;
                        borrow   <= bin;
                        cnt      <= '0;
                        state    <= SHIFT;
                        in_ready <= 1'b0;
                    end
                end
                SHIFT: begin
                    areg   <= areg >> 1;
                    breg   <= breg >> 1;
                    dreg   <= {diffbit, dreg[WIDTH-1:1]};
                    borrow <= borrownext;
                    if (cnt == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        bout      <= borrownext;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
// Scoreboard bench: expected {bout,d} pushed on each accepted operand pair,
// popped and compared on each completed output handshake.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             bout;

    int errors = 0;
    int checks = 0;
    int pushCount = 0;
    int popCount = 0;
    logic [WIDTH:0] sbQ[$];

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .bin(bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .d(d),
        .bout(bout)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference model: 9-bit unsigned subtraction, MSB is the borrow-out
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
        return {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, c};
    endfunction

    // Scoreboard monitor, sampled mid-cycle so the next rising edge decides
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) begin
                sbQ.push_back(model(a, b, bin));
                pushCount++;
            end
            if (out_valid && out_ready) begin
                popCount++;
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_result", {23'd0, bout, d}, 32'hFFFF_FFFF);
                end else begin
                    checkOutput("result", {23'd0, bout, d}, {23'd0, sbQ.pop_front()});
                end
            end
        end
    end

    // Present an operand pair and hold it until the accepting edge
    task automatic applyStimulus(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
        int n;
        in_valid = 1'b1;
        a = x;
        b = y;
        bin = c;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) checkOutput("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait for the result to be handed off (out_ready must already be high)
    task automatic waitResult();
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) checkOutput("result_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        bit done;
        logic [WIDTH:0] exp;

        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        bin = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_d", {24'd0, d}, 32'h00);
        checkOutput("rst_bout", {31'd0, bout}, 32'd0);

        // Basic subtraction with latency measurement
        applyStimulus(8'h5A, 8'h3C, 1'b0);
        checkOutput("in_ready_low", {31'd0, in_ready}, 32'd0);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("latency", n, 32'd8);
        checkOutput("d_5a_3c", {24'd0, d}, 32'h1E);
        waitResult();

        // Underflow and wrap-around
        applyStimulus(8'h00, 8'h01, 1'b0);
        waitResult();
        checkOutput("wrap_d", {24'd0, d}, 32'hFF);
        checkOutput("wrap_bout", {31'd0, bout}, 32'd1);
        applyStimulus(8'hFF, 8'hFF, 1'b1);
        waitResult();
        checkOutput("ff_ff_1_d", {24'd0, d}, 32'hFF);
        checkOutput("ff_ff_1_bout", {31'd0, bout}, 32'd1);

        // Borrow travelling through bits 0..6
        applyStimulus(8'h80, 8'h7F, 1'b1);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            checkOutput("borrow_chain", {31'd0, dut.borrow}, 32'd1);
        end
        waitResult();
        checkOutput("chain_d", {24'd0, d}, 32'h00);
        checkOutput("chain_bout", {31'd0, bout}, 32'd0);

        // Backpressure with input noise while holding the result
        out_ready = 1'b0;
        exp = model(8'hC3, 8'hD4, 1'b0);
        applyStimulus(8'hC3, 8'hD4, 1'b0);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            a = 8'($urandom);
            b = 8'($urandom);
            bin = 1'($urandom);
            @(posedge clk);
            #1;
            checkOutput("bp_d", {24'd0, d}, {24'd0, exp[WIDTH-1:0]});
            checkOutput("bp_bout", {31'd0, bout}, {31'd0, exp[WIDTH]});
            checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("bp_release_out_valid", {31'd0, out_valid}, 32'd0);

        // Reset on the third shift edge
        applyStimulus(8'h12, 8'h34, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sbQ.delete();
        pushCount = popCount;
        checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midrst_d", {24'd0, d}, 32'h00);
        checkOutput("midrst_bout", {31'd0, bout}, 32'd0);
        applyStimulus(8'h34, 8'h12, 1'b0);
        waitResult();
        checkOutput("after_rst_d", {24'd0, d}, 32'h22);
        checkOutput("after_rst_bout", {31'd0, bout}, 32'd0);

        // Random back-to-back traffic with gaps on both sides
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 256; i++) begin
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                    applyStimulus(8'($urandom), 8'($urandom), 1'($urandom));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        n = 0;
        while ((sbQ.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain_empty", sbQ.size(), 32'd0);
        checkOutput("push_pop_count", popCount, pushCount);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial multi-bit subtractor built around a single full-subtractor cell and a borrow flip-flop. It computes d = a − b − bin modulo 2^WIDTH plus a borrow-out, processing one bit per clock, LSB first. It accepts a parallel operand pair through a valid/ready handshake and presents the parallel result through a second valid/ready handshake. It trades WIDTH cycles of latency for one subtractor cell, in place of a WIDTH-cell ripple chain.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- in_valid  input  1  operand pair a/b/bin is valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  d/bout hold a completed result.
- out_ready  input  1  consumer accepts the result.
- d  output  WIDTH  difference, (a − b − bin) mod 2^WIDTH.
- bout  output  1  borrow-out, 1 iff a < b + bin (unsigned).

## Operation
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SHIFT: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Transitions:
  - IDLE→SHIFT on in_valid&&in_ready. Capture a and b into shift registers, bin into the borrow flip-flop, and clear the bit counter.
  - SHIFT→SHIFT while counter < WIDTH−1.
  - SHIFT→DONE on the edge that processes bit WIDTH−1.
  - DONE→IDLE on out_valid&&out_ready.
- Per-bit cell in SHIFT, with x=a_i, y=b_i, br=borrow flip-flop:
  - d_i = x ^ y ^ br
  - br_next = (~x & y) | (~(x ^ y) & br)
- Each SHIFT edge shifts both operand registers right by one.
- Each SHIFT edge shifts d_i into the result register from the MSB end, so after WIDTH edges d[0] is the first processed bit.
- bout is the borrow flip-flop value after bit WIDTH−1.
- Arithmetic is unsigned. The counter is $clog2(WIDTH) bits wide and never wraps past WIDTH−1.
- in_valid and operand inputs are ignored outside IDLE. Operands are sampled only on the accepting edge.
- d and bout are stable and unchanged for the whole time out_valid=1, regardless of in_valid, a, b or bin.
- No same-cycle re-accept: in the cycle after the DONE→IDLE handshake, in_ready=1 and a new operand pair may be accepted.
- Reset mid-operation (SHIFT or DONE) aborts the operation, discards the result, and returns to IDLE.

## Timing
- Reset values: in_ready=1, out_valid=0, d=0, bout=0, state=IDLE, counter=0, borrow flip-flop=0.
- Accept on edge E0. Bits 0..WIDTH−1 are processed on edges E1..E_WIDTH. out_valid is high from E_WIDTH onward.
- Latency is WIDTH cycles from accept to out_valid.
- Minimum issue interval is WIDTH+2 cycles (accept, WIDTH shifts, output handshake, IDLE).
- in_ready is low starting the cycle after the accepting edge.
- out_valid drops the cycle after the out_valid&&out_ready edge.
- Backpressure: with out_ready=0 the block stays in DONE indefinitely with outputs frozen.
- rst has priority over all handshakes on the same edge. If in_valid=1 and rst=1 on one edge, nothing is accepted.

## Test plan
- Reset: assert rst for 2 cycles → in_ready=1, out_valid=0, d=0x00, bout=0. Then with WIDTH=8, a=0x5A, b=0x3C, bin=0, out_ready=1 → out_valid 8 cycles after accept, d=0x1E, bout=0.
- Underflow and wrap-around: a=0x00, b=0x01, bin=0 → d=0xFF, bout=1. Then a=0xFF, b=0xFF, bin=1 → d=0xFF, bout=1.
- Borrow propagation through all bits: a=0x80, b=0x7F, bin=1 → d=0x00, bout=0. Check the borrow flip-flop stays high for bits 0..6.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. While doing so, toggle in_valid, a and b. Required: d and bout are unchanged, in_ready=0, nothing is accepted. Raise out_ready → handshake, and in_ready=1 on the next cycle.
- Reset mid-shift: assert rst on the 3rd SHIFT edge of a=0x12, b=0x34. Required: next cycle in_ready=1, out_valid=0, d=0, bout=0. A following a=0x34, b=0x12, bin=0 gives d=0x22, bout=0.
- Back-to-back: run 256 random operand pairs with random in_valid and out_ready gaps. Compare every result against a − b − bin computed in 9 bits; no result is lost or duplicated.
